// File: rtl/data_memory_bytelane.sv
// Byte-addressed little-endian data memory (MEM stage): comb read, clocked write,
// zero-fill after reset, sticky fault record. Optional stats: DMEM_ACCESS_STATS_EN.
module data_memory_bytelane #(
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_write_addr,
  input  logic [31:0]           write_data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic                  fault_clear,
  output logic [31:0]           read_data,
  output logic                  init_busy,
  output logic                  misaligned,
  output logic                  fault_sticky,
  output logic [ADDR_WIDTH-1:0] fault_addr
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [31:0]           load_count,
  output logic [31:0]           store_count
`endif
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [31:0]         mem_q [DEPTH];
  logic                fault_q;
  logic [ADDR_WIDTH-1:0] faddr_q;

  logic                ready;
  logic [IW-1:0]       widx;
  logic [1:0]          lane;
  logic                oor;
  logic                mis;
  logic                fault;
  logic [31:0]         rd_word;
  logic [7:0]          b_sel;
  logic [15:0]         h_sel;
  logic [31:0]         load_val;
  logic [3:0]          be;
  logic [31:0]         wd_rep;
  logic                do_store;
  logic                do_load;

  assign ready     = (state_q == READY);
  assign init_busy = (state_q == INIT);
  assign widx      = read_write_addr[IW+1:2];
  assign lane      = read_write_addr[1:0];
  assign oor       = (read_write_addr >> (IW + 2)) != '0;

  always_comb begin
    mis = 1'b0;
    unique case (mem_size)
      2'b00: mis = 1'b0;
      2'b01: mis = lane[0];
      2'b10: mis = |lane;
      2'b11: mis = 1'b1;
    endcase
  end

  assign fault      = ready & (MemRead | MemWrite) & (mis | oor);
  assign misaligned = fault;
  assign do_store   = ready & MemWrite & ~fault;
  assign do_load    = ready & MemRead & ~fault;

  assign rd_word = mem_q[widx];
  assign b_sel   = rd_word[8*lane +: 8];
  assign h_sel   = rd_word[16*lane[1] +: 16];

  always_comb begin
    load_val = '0;
    be       = 4'b0000;
    wd_rep   = write_data;
    unique case (mem_size)
      2'b00: begin
        load_val = {{24{~mem_unsigned & b_sel[7]}}, b_sel};
        be       = 4'b0001 << lane;
        wd_rep   = {4{write_data[7:0]}};
      end
      2'b01: begin
        load_val = {{16{~mem_unsigned & h_sel[15]}}, h_sel};
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep   = {2{write_data[15:0]}};
      end
      2'b10: begin
        load_val = rd_word;
        be       = 4'b1111;
      end
      2'b11: begin
        load_val = '0;
        be       = 4'b0000;
      end
    endcase
  end

  assign read_data = do_load ? load_val : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = READY;
      end
      READY: state_d = READY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? INIT : READY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage has no reset; the INIT sweep zero-fills it instead.
  always_ff @(posedge clock) begin
    if (state_q == INIT) begin
      mem_q[idx_q] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[widx][8*b +: 8] <= wd_rep[8*b +: 8];
    end
  end

  // A new fault beats a simultaneous clear; otherwise first fault is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else if (fault && (!fault_q || fault_clear)) begin
      fault_q <= 1'b1;
      faddr_q <= read_write_addr;
    end else if (fault_clear) begin
      fault_q <= 1'b0;
      faddr_q <= '0;
    end
  end

  assign fault_sticky = fault_q;
  assign fault_addr   = faddr_q;

`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] ld_cnt_q, st_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (do_load && ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 1'b1;
      if (do_store && st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
    end
  end

  assign load_count  = ld_cnt_q;
  assign store_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed self-checking bench for data_memory_bytelane (DEPTH=256).
// Covers clear FSM, lane stores, extension, faults, reset restart, stats.
module tb_data_memory_bytelane;

  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] read_write_addr = '0;
  logic [31:0]   write_data = '0;
  logic          MemWrite = 1'b0;
  logic          MemRead = 1'b0;
  logic [1:0]    mem_size = 2'b10;
  logic          mem_unsigned = 1'b0;
  logic          fault_clear = 1'b0;
  logic [31:0]   read_data;
  logic          init_busy;
  logic          misaligned;
  logic          fault_sticky;
  logic [AW-1:0] fault_addr;
`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0]   load_count;
  logic [31:0]   store_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  always #5 clock = ~clock;

  data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .read_write_addr(read_write_addr),
    .write_data(write_data),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .fault_clear(fault_clear),
    .read_data(read_data),
    .init_busy(init_busy),
    .misaligned(misaligned),
    .fault_sticky(fault_sticky),
    .fault_addr(fault_addr)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .load_count(load_count),
    .store_count(store_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d,
                     input logic wr, input logic rd, input logic [1:0] sz,
                     input logic uns, input logic fc);
    read_write_addr = a;
    write_data      = d;
    MemWrite        = wr;
    MemRead         = rd;
    mem_size        = sz;
    mem_unsigned    = uns;
    fault_clear     = fc;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 2'b10, 0, 0);
  endtask

  task automatic wait_init(output int c);
    c = 0;
    while (init_busy === 1'b1 && c < 1000) begin
      tick();
      c++;
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_sticky", {31'd0, fault_sticky}, 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);

    // store attempted throughout INIT must be ignored
    drv(32'h0, 32'hFFFF_FFFF, 1, 1, 2'b10, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
      if (cnt == 50) begin
        drv(32'h3FF, 32'hFFFF_FFFF, 1, 1, 2'b10, 0, 0);
        chk("init_mis", {31'd0, misaligned}, 32'd0);
        chk("init_rd", read_data, 32'd0);
        drv(32'h0, 32'hFFFF_FFFF, 1, 1, 2'b10, 0, 0);
      end
    end
    idle();
    chk("init_cycles", cnt, 32'd256);
    chk("init_nofault", {31'd0, fault_sticky}, 32'd0);

    drv(32'h0, 0, 0, 1, 2'b10, 0, 0);
    chk("clr_0x0", read_data, 32'd0);
    drv(32'h200, 0, 0, 1, 2'b10, 0, 0);
    chk("clr_0x200", read_data, 32'd0);
    drv(32'h3FC, 0, 0, 1, 2'b10, 0, 0);
    chk("clr_0x3FC", read_data, 32'd0);

    // word then byte store
    drv(32'h4, 32'h1122_3344, 1, 0, 2'b10, 0, 0);
    tick();
    drv(32'h6, 32'h0000_00AA, 1, 0, 2'b00, 0, 0);
    tick();
    drv(32'h4, 0, 0, 1, 2'b10, 0, 0);
    chk("lw_0x4", read_data, 32'h11AA_3344);
    drv(32'h6, 0, 0, 1, 2'b00, 1, 0);
    chk("lbu_0x6", read_data, 32'h0000_00AA);
    drv(32'h6, 0, 0, 1, 2'b00, 0, 0);
    chk("lb_0x6", read_data, 32'hFFFF_FFAA);

    // half store
    drv(32'hA, 32'h0000_8001, 1, 0, 2'b01, 0, 0);
    tick();
    drv(32'hA, 0, 0, 1, 2'b01, 0, 0);
    chk("lh_0xA", read_data, 32'hFFFF_8001);
    drv(32'hA, 0, 0, 1, 2'b01, 1, 0);
    chk("lhu_0xA", read_data, 32'h0000_8001);
    drv(32'h8, 0, 0, 1, 2'b01, 1, 0);
    chk("lhu_0x8", read_data, 32'h0000_0000);
    chk("pre_sticky", {31'd0, fault_sticky}, 32'd0);

    // misaligned word store then misaligned half load
    drv(32'h5, 32'hDEAD_BEEF, 1, 0, 2'b10, 0, 0);
    chk("sw5_mis", {31'd0, misaligned}, 32'd1);
    tick();
    chk("sw5_sticky", {31'd0, fault_sticky}, 32'd1);
    chk("sw5_faddr", fault_addr, 32'h5);
    drv(32'h7, 0, 0, 1, 2'b01, 0, 0);
    chk("lh7_mis", {31'd0, misaligned}, 32'd1);
    chk("lh7_rd", read_data, 32'd0);
    tick();
    chk("lh7_faddr", fault_addr, 32'h5);
    drv(32'h4, 0, 0, 1, 2'b10, 0, 0);
    chk("sw5_nowrite", read_data, 32'h11AA_3344);

    // out-of-range store with simultaneous clear
    drv(32'h400, 32'h0000_0055, 1, 0, 2'b10, 0, 1);
    chk("oor_mis", {31'd0, misaligned}, 32'd1);
    tick();
    chk("oor_sticky", {31'd0, fault_sticky}, 32'd1);
    chk("oor_faddr", fault_addr, 32'h400);
    drv(32'h0, 0, 0, 1, 2'b10, 0, 0);
    chk("oor_nowrap", read_data, 32'd0);

    // plain clear
    drv(32'h0, 0, 0, 0, 2'b10, 0, 1);
    tick();
    chk("clr_sticky", {31'd0, fault_sticky}, 32'd0);
    chk("clr_faddr", fault_addr, 32'd0);

    // read and write same word
    drv(32'h10, 32'hCAFE_F00D, 1, 1, 2'b10, 0, 0);
    chk("rw_old", read_data, 32'd0);
    tick();
    chk("rw_new", read_data, 32'hCAFE_F00D);
    idle();

    // illegal size
    drv(32'h0, 0, 0, 1, 2'b11, 0, 0);
    chk("sz11_mis", {31'd0, misaligned}, 32'd1);
    chk("sz11_rd", read_data, 32'd0);
    idle();
    tick();

    // reset mid-clear restarts the sweep
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst2_sticky", {31'd0, fault_sticky}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (100) tick();
    chk("mid_busy", {31'd0, init_busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, init_busy}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    wait_init(cnt);
    chk("reinit_cycles", cnt, 32'd256);
    drv(32'h10, 0, 0, 1, 2'b10, 0, 0);
    chk("reinit_clr", read_data, 32'd0);
    idle();

`ifdef DMEM_ACCESS_STATS_EN
    chk("st_rst_ld", load_count, 32'd0);
    chk("st_rst_st", store_count, 32'd0);
    drv(32'h0, 32'h8765_4321, 1, 0, 2'b10, 0, 0);
    tick();
    drv(32'h1, 32'h0000_00FF, 1, 0, 2'b00, 0, 0);
    tick();
    drv(32'h0, 0, 0, 1, 2'b10, 0, 0);
    tick();
    drv(32'h1, 0, 0, 1, 2'b00, 0, 0);
    tick();
    drv(32'h2, 0, 0, 1, 2'b01, 0, 0);
    tick();
    drv(32'h3, 0, 0, 1, 2'b01, 0, 0);
    tick();
    idle();
    chk("st_ld", load_count, 32'd3);
    chk("st_st", store_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
